sha2_multiblock: RTL and testbench

Parametrised SHA-256/SHA-224 compression engine for the signature authenticator datapath. It hashes messages of any number of pre-padded 512-bit blocks by chaining the intermediate hash across blocks. It computes 1, 2 or 4 rounds per clock and uses a valid/ready block-input handshake. It sits between the message padder and the signature verifier and produces one digest update per accepted block.

---
 rtl/sha2_multiblock_if.sv | 22 ++
 rtl/sha2_multiblock.sv | 175 +++++++++++++++++
 tb/tb_sha2_multiblock.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sha2_multiblock_if.sv
// Block-input handshake and digest output bundle between the message padder,
// the SHA-2 compression engine and the signature verifier.
interface sha2_multiblock_if;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         mode_224;
   logic [255:0] digest;
   logic         digest_valid;
   logic         busy;

   modport master (
      output blk_valid, blk_data, blk_first, mode_224,
      input  blk_ready, digest, digest_valid, busy
   );

   modport slave (
      input  blk_valid, blk_data, blk_first, mode_224,
      output blk_ready, digest, digest_valid, busy
   );
endinterface

// File: rtl/sha2_multiblock.sv
// SHA-256/SHA-224 compression engine: UNROLL rounds per clock, chaining the
// intermediate hash across pre-padded 512-bit blocks.
module sha2_multiblock #(
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             srst,
   sha2_multiblock_if.slave bus
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("sha2_multiblock: UNROLL must be 1, 2 or 4");
   end

   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {IDLE, ROUND, UPDATE} state_t;

   localparam logic [5:0] RND_STEP = 6'(UNROLL);
   localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

   localparam word_t IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam word_t IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t bsig0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t bsig1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ssig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   state_t       state_q, state_d;
   logic [5:0]   rnd_q, rnd_d;
   word_t        w_q [16];
   word_t        w_d [16];
   word_t        v_q [8];
   word_t        v_d [8];
   word_t        h_q [8];
   word_t        h_d [8];
   logic         mode_q, mode_d;
   logic [255:0] digest_q, digest_d;
   logic         dvalid_q, dvalid_d;
   logic         busy_q, busy_d;

   word_t        v_rnd [8];
   word_t        w_rnd [16];
   logic         accept;

   assign bus.blk_ready    = (state_q == IDLE) && !srst;
   assign bus.digest       = digest_q;
   assign bus.digest_valid = dvalid_q;
   assign bus.busy         = busy_q;
   assign accept           = bus.blk_valid && bus.blk_ready;

   // UNROLL rounds chained in one cycle; w_rnd[0] is always W[t] of the round being applied.
   always_comb begin : round_logic
      word_t      t1, t2, wn;
      logic [5:0] ridx;
      t1    = '0;
      t2    = '0;
      wn    = '0;
      ridx  = '0;
      v_rnd = v_q;
      w_rnd = w_q;
      for (int u = 0; u < UNROLL; u++) begin
         ridx = rnd_q + 6'(u);
         t1   = v_rnd[7] + bsig1(v_rnd[4]) + ch(v_rnd[4], v_rnd[5], v_rnd[6]) + K[ridx] + w_rnd[0];
         t2   = bsig0(v_rnd[0]) + maj(v_rnd[0], v_rnd[1], v_rnd[2]);
         wn   = ssig1(w_rnd[14]) + w_rnd[9] + ssig0(w_rnd[1]) + w_rnd[0];
         for (int j = 7; j > 0; j--) v_rnd[j] = v_rnd[j-1];
         v_rnd[4] = v_rnd[4] + t1;
         v_rnd[0] = t1 + t2;
         for (int j = 0; j < 15; j++) w_rnd[j] = w_rnd[j+1];
         w_rnd[15] = wn;
      end
   end

   always_comb begin
      state_d  = state_q;
      rnd_d    = rnd_q;
      w_d      = w_q;
      v_d      = v_q;
      h_d      = h_q;
      mode_d   = mode_q;
      digest_d = digest_q;
      dvalid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               for (int j = 0; j < 16; j++) w_d[j] = bus.blk_data[511 - 32*j -: 32];
               if (bus.blk_first) begin
                  mode_d = bus.mode_224;
                  if (bus.mode_224) h_d = IV224;
                  else              h_d = IV256;
               end
               v_d     = h_d;
               rnd_d   = '0;
               state_d = ROUND;
            end
         end
         ROUND: begin
            v_d   = v_rnd;
            w_d   = w_rnd;
            rnd_d = rnd_q + RND_STEP;
            if (rnd_q == LAST_RND) state_d = UPDATE;
         end
         UPDATE: begin
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
            // SHA-224 truncates to H0..H6; the low word is zeroed rather than left stale.
            if (mode_q) digest_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], 32'h0};
            else        digest_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6], h_d[7]};
            dvalid_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q  <= IDLE;
         rnd_q    <= '0;
         h_q      <= IV256;
         mode_q   <= 1'b0;
         digest_q <= '0;
         dvalid_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         h_q      <= h_d;
         mode_q   <= mode_d;
         digest_q <= digest_d;
         dvalid_q <= dvalid_d;
         busy_q   <= busy_d;
      end
      w_q <= w_d;
      v_q <= v_d;
   end

endmodule

// File: tb/tb_sha2_multiblock.sv
// Directed bench for sha2_multiblock: one instance each for UNROLL 1, 2 and 4,
// checked against known SHA-256/SHA-224 digests.
module tb_sha2_multiblock;

   localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO2  = {480'h0, 32'h000001c0};
   localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};

   localparam logic [255:0] D_ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic         clk;
   logic         srst;
   logic         vld  [3];
   logic [511:0] dat  [3];
   logic         fst  [3];
   logic         m224 [3];
   logic         rdy  [3];
   logic [255:0] dig  [3];
   logic         dv   [3];
   logic         bsy  [3];

   int checks;
   int errs;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sha2_multiblock_if bus ();
      assign bus.blk_valid = vld[g];
      assign bus.blk_data  = dat[g];
      assign bus.blk_first = fst[g];
      assign bus.mode_224  = m224[g];
      assign rdy[g]        = bus.blk_ready;
      assign dig[g]        = bus.digest;
      assign dv[g]         = bus.digest_valid;
      assign bsy[g]        = bus.busy;
      sha2_multiblock #(.UNROLL(1 << g)) u_dut (
         .clk  (clk),
         .srst (srst),
         .bus  (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Called at a negedge where the instance is expected to be ready.
   task automatic send(input int k, input logic [511:0] d, input logic first, input logic m);
      dat[k]  = d;
      fst[k]  = first;
      m224[k] = m;
      vld[k]  = 1'b1;
      check($sformatf("rdy_at_send_u%0d", k), 256'(rdy[k]), 256'd1);
   endtask

   // Steps negedges until digest_valid; returns positioned in the digest_valid cycle.
   task automatic wait_done(input int k, input int lat, input logic hold, input logic chk_dig,
                            input logic [255:0] exp, input string tag);
      int           n;
      logic         early;
      logic         moved;
      logic         seen;
      logic [255:0] d0;
      n = 0; early = 1'b0; moved = 1'b0; seen = 1'b0; d0 = dig[k];
      while (!seen && n < lat + 4) begin
         @(negedge clk);
         n++;
         if (n == 1 && !hold) vld[k] = 1'b0;
         if (dv[k]) seen = 1'b1;
         else begin
            if (rdy[k] || !bsy[k]) early = 1'b1;
            if (dig[k] !== d0) moved = 1'b1;
         end
      end
      check($sformatf("%s_latency", tag), 256'(n), 256'(lat));
      check($sformatf("%s_ready_low", tag), 256'(early), 256'd0);
      check($sformatf("%s_digest_held", tag), 256'(moved), 256'd0);
      check($sformatf("%s_ready_at_done", tag), 256'(rdy[k]), 256'd1);
      check($sformatf("%s_idle_at_done", tag), 256'(bsy[k]), 256'd0);
      if (chk_dig) check($sformatf("%s_digest", tag), dig[k], exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      checks = 0;
      errs   = 0;
      srst   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vld[k] = 1'b1; dat[k] = ABC; fst[k] = 1'b1; m224[k] = 1'b0;
      end

      repeat (2) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_digest_u%0d", k), dig[k], 256'd0);
            check($sformatf("rst_dvalid_u%0d", k), 256'(dv[k]), 256'd0);
            check($sformatf("rst_busy_u%0d", k), 256'(bsy[k]), 256'd0);
            check($sformatf("rst_ready_u%0d", k), 256'(rdy[k]), 256'd0);
         end
      end
      srst = 1'b0;
      for (int k = 0; k < 3; k++) vld[k] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("post_rst_ready_u%0d", k), 256'(rdy[k]), 256'd1);
         check($sformatf("post_rst_busy_u%0d", k), 256'(bsy[k]), 256'd0);
      end

      // UNROLL=1 directed messages
      send(0, ABC, 1'b1, 1'b0);
      wait_done(0, 66, 1'b0, 1'b1, D_ABC, "u1_abc");
      send(0, TWO1, 1'b1, 1'b0);
      wait_done(0, 66, 1'b0, 1'b0, 256'd0, "u1_two_blk1");
      send(0, TWO2, 1'b0, 1'b0);
      wait_done(0, 66, 1'b0, 1'b1, D_TWO, "u1_two_blk2");
      send(0, ABC, 1'b1, 1'b1);
      wait_done(0, 66, 1'b0, 1'b1, D_ABC224, "u1_abc224");
      send(0, EMPTY, 1'b1, 1'b0);
      wait_done(0, 66, 1'b0, 1'b1, D_EMPTY, "u1_empty");
      @(negedge clk);
      check("u1_dvalid_one_cycle", 256'(dv[0]), 256'd0);

      // Reset during round 30 of a SHA-224 block
      send(0, ABC, 1'b1, 1'b1);
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (30) @(negedge clk);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      check("midrst_busy", 256'(bsy[0]), 256'd0);
      check("midrst_dvalid", 256'(dv[0]), 256'd0);
      check("midrst_digest", dig[0], 256'd0);
      @(negedge clk);
      check("midrst_ready", 256'(rdy[0]), 256'd1);
      check("midrst_no_dvalid", 256'(dv[0]), 256'd0);
      // blk_first=0 after reset must hash as SHA-256 from the IV; mode_224 is ignored
      send(0, ABC, 1'b0, 1'b1);
      wait_done(0, 66, 1'b0, 1'b1, D_ABC, "u1_abc_nofirst_after_rst");
      send(0, ABC, 1'b1, 1'b0);
      wait_done(0, 66, 1'b0, 1'b1, D_ABC, "u1_abc_after_rst");

      // Back-to-back with valid held high, UNROLL=2 and UNROLL=4
      for (int k = 1; k < 3; k++) begin
         lat = 64 / (1 << k) + 2;
         send(k, ABC, 1'b1, 1'b0);
         wait_done(k, lat, 1'b1, 1'b1, D_ABC, $sformatf("u%0d_abc", 1 << k));
         send(k, TWO1, 1'b1, 1'b0);
         wait_done(k, lat, 1'b1, 1'b0, 256'd0, $sformatf("u%0d_two_blk1", 1 << k));
         send(k, TWO2, 1'b0, 1'b0);
         wait_done(k, lat, 1'b1, 1'b1, D_TWO, $sformatf("u%0d_two_blk2", 1 << k));
         send(k, ABC, 1'b1, 1'b1);
         wait_done(k, lat, 1'b1, 1'b1, D_ABC224, $sformatf("u%0d_abc224", 1 << k));
         send(k, EMPTY, 1'b1, 1'b0);
         wait_done(k, lat, 1'b0, 1'b1, D_EMPTY, $sformatf("u%0d_empty", 1 << k));
         @(negedge clk);
         check($sformatf("u%0d_dvalid_one_cycle", 1 << k), 256'(dv[k]), 256'd0);
         check($sformatf("u%0d_idle_after", 1 << k), 256'(bsy[k]), 256'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule
